// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-stage definitions: word width, R_W encoding, access FSM states.
package lc3_pkg;

  localparam int LC3_WORD_W = 16;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2,
    MEM_HOLD   = 2'd3
  } mem_state_e;

  // A disabled timeout (0) still needs a 1-bit counter to stay a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lc3_mem_interface_if.sv
// Memory-side bus between the LC-3 memory stage (master) and the memory (slave).
interface lc3_mem_interface_if
  import lc3_pkg::*;
#(
  parameter int ADDR_W = LC3_WORD_W,
  parameter int DATA_W = LC3_WORD_W
);
  // Handshake: MEM_REQ rises when an access starts and stays high until the
  // cycle after MEM_ACK (or a timeout); MEM_WE/MEM_ADDR/MEM_WDATA are stable
  // throughout. MEM_ACK is a one-cycle completion pulse, MEM_RDATA is valid
  // with it, and an ack seen while MEM_REQ is low is ignored.
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic              MEM_ACK;

  modport master (
    output MEM_ADDR, MEM_WDATA, MEM_REQ, MEM_WE,
    input  MEM_RDATA, MEM_ACK
  );

  modport slave (
    input  MEM_ADDR, MEM_WDATA, MEM_REQ, MEM_WE,
    output MEM_RDATA, MEM_ACK
  );

endinterface

// File: rtl/lc3_timeout_counter.sv
// Saturating cycle counter with synchronous clear and a flag at the compare value.
module lc3_timeout_counter
  import lc3_pkg::*;
#(
  parameter int CMP = 255,
  parameter int W   = cnt_width(CMP)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic reached_o
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CMP_V   = W'(CMP);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // CMP of 0 means the timeout is disabled.
  assign reached_o = (CMP != 0) && (cnt_q == CMP_V);

endmodule

// File: rtl/lc3_mem_interface.sv
// LC-3 memory access stage: MAR/MDR registers plus a one-access-per-request FSM
// with a memory req/ack handshake, a timeout, and a one-cycle R pulse to control.
module lc3_mem_interface
  import lc3_pkg::*;
#(
  parameter int ADDR_W         = LC3_WORD_W,
  parameter int DATA_W         = LC3_WORD_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] BUS,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  input  logic              ERR_CLR,
  output logic [ADDR_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic              R,
  output logic              ERR,
  output mem_state_e        state_o,
  lc3_mem_interface_if.master mem
);

  mem_state_e        state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              req_q;
  logic              we_q;
  logic              r_q;
  logic              err_q;

  logic cnt_clr;
  logic cnt_en;
  logic reached;
  logic timeout_hit;

  assign cnt_clr     = (state_q == MEM_IDLE);
  assign cnt_en      = (state_q == MEM_ACCESS) && !mem.MEM_ACK;
  // An ack arriving on the reached cycle completes the access normally.
  assign timeout_hit = (state_q == MEM_ACCESS) && !mem.MEM_ACK && reached;

  lc3_timeout_counter #(
    .CMP (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .reached_o (reached)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= MEM_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      r_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      r_q <= 1'b0;

      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (ERR_CLR) begin
        err_q <= 1'b0;
      end

      case (state_q)
        MEM_IDLE: begin
          if (LD_MAR) begin
            mar_q <= ADDR_W'(BUS);
          end
          if (LD_MDR && !MIO_EN) begin
            mdr_q <= BUS;
          end
          if (MIO_EN) begin
            state_q <= MEM_ACCESS;
            req_q   <= 1'b1;
            we_q    <= R_W;
          end
        end
        MEM_ACCESS: begin
          if (mem.MEM_ACK) begin
            if (we_q == MEM_READ) begin
              mdr_q <= mem.MEM_RDATA;
            end
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b1;
            state_q <= MEM_DONE;
          end else if (reached) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b1;
            state_q <= MEM_DONE;
          end
        end
        MEM_DONE: begin
          state_q <= MIO_EN ? MEM_HOLD : MEM_IDLE;
        end
        // A still-asserted MIO_EN must drop before another access can start.
        MEM_HOLD: begin
          if (!MIO_EN) begin
            state_q <= MEM_IDLE;
          end
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

  assign MAR           = mar_q;
  assign MDR           = mdr_q;
  assign R             = r_q;
  assign ERR           = err_q;
  assign state_o       = state_q;
  assign mem.MEM_ADDR  = mar_q;
  assign mem.MEM_WDATA = mdr_q;
  assign mem.MEM_REQ   = req_q;
  assign mem.MEM_WE    = we_q;

endmodule

// File: tb/tb_lc3_mem_interface.sv
// Directed bench for lc3_mem_interface: stimulus pushes expected {MAR,MDR,ERR}
// per access; a monitor pops and compares on every R pulse.
module tb_lc3_mem_interface;
  import lc3_pkg::*;

  localparam int W     = 16;
  localparam int EXP_W = 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] bus;
  logic         ld_mar, ld_mdr, mio_en, r_w, err_clr;
  logic [W-1:0] mar, mdr;
  logic         r, err;
  mem_state_e   state;

  lc3_mem_interface_if mem_if ();

  lc3_mem_interface #(
    .ADDR_W         (W),
    .DATA_W         (W),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .BUS     (bus),
    .LD_MAR  (ld_mar),
    .LD_MDR  (ld_mdr),
    .MIO_EN  (mio_en),
    .R_W     (r_w),
    .ERR_CLR (err_clr),
    .MAR     (mar),
    .MDR     (mdr),
    .R       (r),
    .ERR     (err),
    .state_o (state),
    .mem     (mem_if)
  );

  // ---------------- scoreboard ----------------
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic             r_prev   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("we_only_with_req", 64'(mem_if.MEM_WE & ~mem_if.MEM_REQ), 64'd0);
      if (r) begin
        logic [EXP_W-1:0] exp_v;
        check("r_single_cycle", 64'(r_prev), 64'd0);
        check("req_low_at_r", 64'(mem_if.MEM_REQ), 64'd0);
        check("r_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("result_mar_mdr_err", 64'({mar, mdr, err}), 64'(exp_v));
        end
      end
      r_prev = r;
    end else begin
      r_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [W-1:0] v);
    bus    = v;
    ld_mar = 1'b1;
    tick();
    ld_mar = 1'b0;
  endtask

  task automatic load_mdr(input logic [W-1:0] v);
    bus    = v;
    ld_mdr = 1'b1;
    tick();
    ld_mdr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bus              = '0;
    ld_mar           = 1'b0;
    ld_mdr           = 1'b0;
    mio_en           = 1'b0;
    r_w              = MEM_READ;
    err_clr          = 1'b0;
    mem_if.MEM_ACK   = 1'b0;
    mem_if.MEM_RDATA = '0;

    repeat (2) tick();
    check("rst_mar", 64'(mar), 64'd0);
    check("rst_mdr", 64'(mdr), 64'd0);
    check("rst_req", 64'(mem_if.MEM_REQ), 64'd0);
    check("rst_we", 64'(mem_if.MEM_WE), 64'd0);
    check("rst_r", 64'(r), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_state", 64'(state), 64'(MEM_IDLE));
    rst_n = 1'b1;
    tick();

    // Read with ack two cycles after MEM_REQ rises.
    load_mar(16'h3000);
    check("mar_load", 64'(mar), 64'h3000);
    exp_q.push_back({16'h3000, 16'hBEEF, 1'b0});
    mio_en = 1'b1;
    r_w    = MEM_READ;
    tick();
    check("rd_req", 64'(mem_if.MEM_REQ), 64'd1);
    check("rd_we", 64'(mem_if.MEM_WE), 64'd0);
    check("rd_addr", 64'(mem_if.MEM_ADDR), 64'h3000);
    tick();
    tick();
    mem_if.MEM_RDATA = 16'hBEEF;
    mem_if.MEM_ACK   = 1'b1;
    tick();
    mem_if.MEM_ACK   = 1'b0;
    mem_if.MEM_RDATA = '0;
    check("rd_r", 64'(r), 64'd1);
    check("rd_mdr", 64'(mdr), 64'hBEEF);
    mio_en = 1'b0;
    tick();
    check("rd_idle", 64'(state), 64'(MEM_IDLE));

    // Write with immediate ack, then MIO_EN held after R.
    load_mar(16'h4010);
    load_mdr(16'h1234);
    check("mdr_load", 64'(mdr), 64'h1234);
    exp_q.push_back({16'h4010, 16'h1234, 1'b0});
    mio_en = 1'b1;
    r_w    = MEM_WRITE;
    tick();
    check("wr_req", 64'(mem_if.MEM_REQ), 64'd1);
    check("wr_we", 64'(mem_if.MEM_WE), 64'd1);
    check("wr_wdata", 64'(mem_if.MEM_WDATA), 64'h1234);
    check("wr_addr", 64'(mem_if.MEM_ADDR), 64'h4010);
    mem_if.MEM_RDATA = 16'hDEAD;
    mem_if.MEM_ACK   = 1'b1;
    tick();
    check("wr_r", 64'(r), 64'd1);
    check("wr_mdr_kept", 64'(mdr), 64'h1234);
    mem_if.MEM_RDATA = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      mem_if.MEM_ACK = 1'b0;
      check("hold_state", 64'(state), 64'(MEM_HOLD));
      check("hold_no_req", 64'(mem_if.MEM_REQ), 64'd0);
    end
    check("stray_ack_mdr", 64'(mdr), 64'h1234);
    mio_en = 1'b0;
    tick();
    check("hold_release", 64'(state), 64'(MEM_IDLE));
    exp_q.push_back({16'h4010, 16'h0F0F, 1'b0});
    mio_en = 1'b1;
    r_w    = MEM_READ;
    tick();
    check("rereq_req", 64'(mem_if.MEM_REQ), 64'd1);
    mem_if.MEM_RDATA = 16'h0F0F;
    mem_if.MEM_ACK   = 1'b1;
    tick();
    mem_if.MEM_ACK = 1'b0;
    mio_en         = 1'b0;
    tick();

    // Timeout with illegal loads during ACCESS; ERR_CLR on the set cycle.
    load_mar(16'h5000);
    exp_q.push_back({16'h5000, 16'h0F0F, 1'b1});
    mio_en = 1'b1;
    r_w    = MEM_READ;
    tick();
    n = 1;
    check("to_req", 64'(mem_if.MEM_REQ), 64'd1);
    bus    = 16'hFFFF;
    ld_mar = 1'b1;
    ld_mdr = 1'b1;
    tick();
    n      = 2;
    ld_mar = 1'b0;
    ld_mdr = 1'b0;
    check("illegal_mar", 64'(mar), 64'h5000);
    check("illegal_mdr", 64'(mdr), 64'h0F0F);
    check("illegal_addr", 64'(mem_if.MEM_ADDR), 64'h5000);
    while (!r && n < 20) begin
      tick();
      n++;
      err_clr = (n == 5);
    end
    check("to_latency", 64'(n), 64'd6);
    check("to_err", 64'(err), 64'd1);
    check("to_mdr", 64'(mdr), 64'h0F0F);
    mio_en  = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 64'(err), 64'd0);

    // Ack on the same cycle the timeout is reached.
    load_mar(16'h6000);
    exp_q.push_back({16'h6000, 16'hA5A5, 1'b0});
    mio_en = 1'b1;
    repeat (5) tick();
    check("race_state", 64'(state), 64'(MEM_ACCESS));
    mem_if.MEM_RDATA = 16'hA5A5;
    mem_if.MEM_ACK   = 1'b1;
    tick();
    mem_if.MEM_ACK = 1'b0;
    check("race_r", 64'(r), 64'd1);
    check("race_err", 64'(err), 64'd0);
    check("race_mdr", 64'(mdr), 64'hA5A5);
    mio_en = 1'b0;
    tick();

    // Asynchronous reset mid-access, then a late ack.
    load_mar(16'h7000);
    load_mdr(16'h7777);
    mio_en = 1'b1;
    r_w    = MEM_WRITE;
    tick();
    check("mid_req", 64'(mem_if.MEM_REQ), 64'd1);
    check("mid_we", 64'(mem_if.MEM_WE), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req", 64'(mem_if.MEM_REQ), 64'd0);
    check("async_we", 64'(mem_if.MEM_WE), 64'd0);
    check("async_r", 64'(r), 64'd0);
    check("async_mar", 64'(mar), 64'd0);
    check("async_mdr", 64'(mdr), 64'd0);
    check("async_state", 64'(state), 64'(MEM_IDLE));
    mio_en           = 1'b0;
    mem_if.MEM_RDATA = 16'h9999;
    mem_if.MEM_ACK   = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    mem_if.MEM_ACK = 1'b0;
    check("late_ack_mdr", 64'(mdr), 64'd0);
    check("late_ack_req", 64'(mem_if.MEM_REQ), 64'd0);
    check("late_ack_state", 64'(state), 64'(MEM_IDLE));

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_interface.md
Name: lc3_mem_interface

Overview:
- Memory access stage directly downstream of the address muxes.
- MAR captures the bus value, which is driven by the MARMUX output through its gate.
- MDR captures the bus value or memory read data.
- A small FSM runs one memory read or write per request, with a ready/acknowledge handshake to memory and a one-cycle R (ready) pulse back to the LC-3 control FSM.

Parameters:
- ADDR_W, 16, memory address width (equals the datapath width).
- DATA_W, 16, data width.
- TIMEOUT_CYCLES, 255, number of cycles waiting for MEM_ACK before the access aborts with an error; 0 disables the timeout.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- BUS  input  DATA_W  datapath bus (MARMUX/ALU/PC gated result).
- LD_MAR  input  1  load MAR from BUS.
- LD_MDR  input  1  load MDR from BUS (only when MIO_EN=0).
- MIO_EN  input  1  memory access request from control, level, held until R is seen.
- R_W  input  1  access type: 0 = read, 1 = write; sampled when the access starts.
- ERR_CLR  input  1  clears ERR.
- MEM_RDATA  input  DATA_W  memory read data, valid with MEM_ACK.
- MEM_ACK  input  1  memory completion, one-cycle pulse.
- MAR  output  ADDR_W  memory address register.
- MDR  output  DATA_W  memory data register (feeds GateMDR).
- MEM_ADDR  output  ADDR_W  equals MAR.
- MEM_WDATA  output  DATA_W  equals MDR.
- MEM_REQ  output  1  access in flight.
- MEM_WE  output  1  write strobe qualifier, valid while MEM_REQ=1.
- R  output  1  access-complete pulse to control.
- ERR  output  1  sticky timeout flag.

Behaviour:
- Reset (async, RST_N=0): all outputs 0; MAR=0, MDR=0; FSM state IDLE; timeout counter 0.
- Registers:
  - LD_MAR=1 in IDLE: MAR<=BUS on the next edge.
  - LD_MAR while not IDLE: ignored; MAR is stable for the whole access.
  - LD_MDR=1 and MIO_EN=0 in IDLE: MDR<=BUS.
  - LD_MDR while MIO_EN=1 or not IDLE: ignored.
  - LD_MAR and LD_MDR in the same IDLE cycle: both load.
- FSM states: IDLE, ACCESS, DONE, HOLD.
  - IDLE -> ACCESS: when MIO_EN=1. Latch R_W into MEM_WE; MEM_REQ=1 from the next cycle; counter cleared.
  - ACCESS, MEM_ACK=1:
    - Read: MDR<=MEM_RDATA.
    - Write: MDR unchanged.
    - Drop MEM_REQ; go to DONE.
  - ACCESS, no ack: the counter increments each cycle. When the counter reaches TIMEOUT_CYCLES (nonzero): ERR<=1, MDR unchanged, drop MEM_REQ, go to DONE.
  - DONE: R=1 for exactly one cycle. Next state is HOLD if MIO_EN is still 1, else IDLE.
  - HOLD: stay until MIO_EN=0, then IDLE. This prevents a held MIO_EN from re-triggering an access; a new access requires MIO_EN to drop for at least one cycle.
- Latency:
  - MEM_REQ rises 1 cycle after MIO_EN is sampled high.
  - R rises 1 cycle after the MEM_ACK cycle.
  - MDR holds read data in the same cycle R=1.
  - Minimum access: MIO_EN at cycle 0, ACK at cycle 1, R at cycle 2.
- MEM_ACK outside ACCESS: ignored; no MDR change.
- MEM_ACK on the same cycle the timeout is reached: the ack wins, ERR is not set.
- ERR:
  - Sticky; cleared by ERR_CLR=1 on the next edge.
  - If ERR_CLR coincides with a new timeout, the set wins.
- Counter: width clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
- Reset mid-access: returns to IDLE immediately; MEM_REQ, MEM_WE and R drop asynchronously. An in-flight ack after reset is ignored.
- MEM_WE is 0 whenever MEM_REQ=0.

Decomposition:
- Shared package lc3_pkg holds:
  - the state enum (MEM_IDLE, MEM_ACCESS, MEM_DONE, MEM_HOLD);
  - the LC3_WORD_W=16 constant;
  - the R_W encoding constants MEM_READ=0, MEM_WRITE=1.
- One sub-module, lc3_timeout_counter: clear, enable, saturating count, and a reached flag at the compare value.
- MAR/MDR registers and the FSM stay in the top module.

Test Plan:
- Reset then read:
  - Stimulus: BUS=0x3000, LD_MAR=1 (1 cycle); MIO_EN=1, R_W=0; MEM_ACK with MEM_RDATA=0xBEEF two cycles after MEM_REQ.
  - Required: MEM_ADDR=0x3000, MEM_WE=0, MDR=0xBEEF, single R pulse, MEM_REQ low after the ack.
- Write:
  - Stimulus: LD_MAR with BUS=0x4010, then LD_MDR with BUS=0x1234, MIO_EN=1, R_W=1, immediate ack.
  - Required: MEM_WE=1 with MEM_REQ, MEM_WDATA=0x1234, MDR still 0x1234 after R.
- Held MIO_EN:
  - Stimulus: keep MIO_EN=1 for 5 cycles after R.
  - Required: FSM in HOLD, no second MEM_REQ; a new request only after MIO_EN drops and rises again.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, no ack.
  - Required: ERR=1 and R pulse 6 cycles after MIO_EN (1 start cycle, then 4 waiting cycles including the reached cycle, then R), MDR unchanged. ERR_CLR clears ERR; ack and timeout on the same cycle leaves ERR=0.
- Illegal loads:
  - Stimulus: LD_MAR (BUS=0xFFFF) and LD_MDR during ACCESS.
  - Required: MAR and MDR unchanged, MEM_ADDR stable.
- Reset mid-access:
  - Stimulus: RST_N=0 while MEM_REQ=1, then a late MEM_ACK.
  - Required: MEM_REQ, MEM_WE, R, MAR and MDR go to 0 without a clock edge; the late ack has no effect.
